// File: rtl/e_muldiv_unit.sv
// e_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit producing HI/LO one bit per cycle.
// Operands are reduced to magnitudes at launch; signs are re-applied in the FIX cycle.
module e_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK_MDU,
    input  logic             RST_MDU,
    input  logic             StartE,
    input  logic [1:0]       MDOpE,
    input  logic             AbortE,
    input  logic [WIDTH-1:0] Op1E,
    input  logic [WIDTH-1:0] Op2E,
    input  logic             MTHIE,
    input  logic             MTLOE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             BusyE,
    output logic             DoneE
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, nextState;
    logic [2*WIDTH-1:0] acc, accNext, prodFix;
    logic [WIDTH-1:0]   opB, absA, absB, quotFix, remFix;
    logic [WIDTH:0]     mulSum, divShift, divDiff;
    logic [CNT_W-1:0]   cnt;
    logic               signA, signB, isDiv, negA, negB, lastIter;

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        negA     = ~MDOpE[0] & Op1E[WIDTH-1];
        negB     = ~MDOpE[0] & Op2E[WIDTH-1];
        absA     = negA ? -Op1E : Op1E;
        absB     = negB ? -Op2E : Op2E;
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : '0);
        divShift = acc[2*WIDTH-1:WIDTH-1];
        divDiff  = divShift - {1'b0, opB};
        accNext  = !isDiv ? {mulSum, acc[WIDTH-1:1]} :
                   divDiff[WIDTH] ? {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                                    {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prodFix  = (signA ^ signB) ? -acc : acc;
        quotFix  = (signA ^ signB) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remFix   = signA ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        lastIter = cnt == CNT_W'(WIDTH - 1);
        BusyE    = state != IDLE;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = StartE ? CALC : IDLE;
            CALC:    nextState = AbortE ? IDLE : (lastIter ? FIX : CALC);
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK_MDU) begin
        if (!RST_MDU) state <= IDLE;
        else          state <= nextState;
    end

    always_ff @(posedge CLK_MDU) begin
        if (!RST_MDU) begin
            HI    <= '0;
            LO    <= '0;
            DoneE <= 1'b0;
            acc   <= '0;
            opB   <= '0;
            cnt   <= '0;
            signA <= 1'b0;
            signB <= 1'b0;
            isDiv <= 1'b0;
        end else begin
            DoneE <= 1'b0;
            if (state == IDLE) begin
                if (StartE) begin
                    acc   <= {{WIDTH{1'b0}}, absA};
                    opB   <= absB;
                    cnt   <= '0;
                    signA <= negA;
                    signB <= negB;
                    isDiv <= MDOpE[1];
                end else begin
                    if (MTHIE) HI <= Op1E;
                    if (MTLOE) LO <= Op1E;
                end
            end else if (state == CALC) begin
                if (!AbortE) begin
                    acc <= accNext;
                    cnt <= cnt + 1'b1;
                end
            end else if (!AbortE) begin
                // a zero divisor leaves the dividend magnitude as remainder, so remFix restores Op1
                HI    <= isDiv ? remFix : prodFix[2*WIDTH-1:WIDTH];
                LO    <= isDiv ? ((opB == '0) ? '1 : quotFix) : prodFix[WIDTH-1:0];
                DoneE <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_e_muldiv_unit.sv
// tb_e_muldiv_unit: scoreboard bench for e_muldiv_unit covering arithmetic, MT writes, stray issue, abort and reset.
module tb_e_muldiv_unit;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
    logic        CLK_MDU = 1'b0, RST_MDU = 1'b0, StartE = 1'b0, AbortE = 1'b0, MTHIE = 1'b0, MTLOE = 1'b0;
    logic [1:0]  MDOpE = 2'b00;
    logic [31:0] Op1E = '0, Op2E = '0, HI, LO;
    logic        BusyE, DoneE;
    int          checks = 0, failures = 0;
    logic [63:0] sb[$];

    always #5 CLK_MDU = ~CLK_MDU;

    e_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK_MDU(CLK_MDU), .RST_MDU(RST_MDU), .StartE(StartE), .MDOpE(MDOpE), .AbortE(AbortE),
        .Op1E(Op1E), .Op2E(Op2E), .MTHIE(MTHIE), .MTLOE(MTLOE),
        .HI(HI), .LO(LO), .BusyE(BusyE), .DoneE(DoneE)
    );

    task automatic tick();
        @(posedge CLK_MDU);
        #1;
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        MDOpE = op; Op1E = a; Op2E = b; StartE = 1'b1;
        tick();
        StartE = 1'b0;
    endtask

    task automatic wait_done(output int busyCyc, output bit ok);
        busyCyc = 0; ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (DoneE) begin ok = 1'b1; break; end
            if (BusyE) busyCyc++;
            tick();
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb2;
        logic signed [63:0] sp;
        sa = a; sb2 = b;
        sp = 64'(sa) * 64'(sb2);
        case (op)
            MULT:    return sp;
            MULTU:   return {32'h0, a} * {32'h0, b};
            DIVU:    return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: return (b == 0) ? {a, 32'hFFFF_FFFF} :
                            (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? {32'h0, 32'h8000_0000} :
                            {32'(sa % sb2), 32'(sa / sb2)};
        endcase
    endfunction

    task automatic test_reset();
        RST_MDU = 1'b0;
        tick(); tick();
        checks++; if (HI !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected %h", HI, 32'h0); end
        checks++; if (LO !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected %h", LO, 32'h0); end
        checks++; if (BusyE !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", BusyE); end
        checks++; if (DoneE !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", DoneE); end
        RST_MDU = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        logic [1:0]  ops[3] = '{MULT, MULTU, MULT};
        logic [31:0] as[3]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs[3]  = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [63:0] ex[3]  = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001};
        logic [63:0] e;
        int busy; bit ok;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ex[i]);
            launch(ops[i], as[i], bs[i]);
            wait_done(busy, ok);
            e = sb.pop_front();
            checks++; if (!ok) begin failures++; $display("FAIL mult%0d_timeout: got no DoneE expected pulse", i); end
            checks++; if (busy !== 33) begin failures++; $display("FAIL mult%0d_busy: got %0d expected 33", i, busy); end
            checks++; if ({HI, LO} !== e) begin failures++; $display("FAIL mult%0d_hilo: got %h expected %h", i, {HI, LO}, e); end
            tick();
            checks++; if (DoneE !== 1'b0) begin failures++; $display("FAIL mult%0d_pulse: got %b expected 0", i, DoneE); end
        end
    endtask

    task automatic test_div();
        logic [1:0]  ops[4] = '{DIV, DIVU, DIVU, DIV};
        logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'd100, 32'd100, 32'h8000_0000};
        logic [31:0] bs[4]  = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
        logic [63:0] ex[4]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
                                64'h0000_0064_FFFF_FFFF, 64'h0000_0000_8000_0000};
        logic [63:0] e;
        int busy; bit ok;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(ex[i]);
            launch(ops[i], as[i], bs[i]);
            wait_done(busy, ok);
            e = sb.pop_front();
            checks++; if (!ok) begin failures++; $display("FAIL div%0d_timeout: got no DoneE expected pulse", i); end
            checks++; if (busy !== 33) begin failures++; $display("FAIL div%0d_busy: got %0d expected 33", i, busy); end
            checks++; if ({HI, LO} !== e) begin failures++; $display("FAIL div%0d_hilo: got %h expected %h", i, {HI, LO}, e); end
        end
    endtask

    task automatic test_mt();
        logic [63:0] e;
        int busy; bit ok;
        MTHIE = 1'b1; MTLOE = 1'b1; Op1E = 32'h1234;
        tick();
        MTHIE = 1'b0; MTLOE = 1'b0;
        checks++; if ({HI, LO} !== {32'h1234, 32'h1234}) begin failures++; $display("FAIL mt_both: got %h expected %h", {HI, LO}, {32'h1234, 32'h1234}); end
        MTLOE = 1'b1; Op1E = 32'h5678;
        tick();
        MTLOE = 1'b0;
        checks++; if ({HI, LO} !== {32'h1234, 32'h5678}) begin failures++; $display("FAIL mt_lo: got %h expected %h", {HI, LO}, {32'h1234, 32'h5678}); end
        sb.push_back(64'd12);
        MTHIE = 1'b1;
        launch(MULTU, 32'd3, 32'd4);
        MTHIE = 1'b0;
        checks++; if (HI !== 32'h1234) begin failures++; $display("FAIL mt_with_start: got %h expected %h", HI, 32'h1234); end
        wait_done(busy, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin failures++; $display("FAIL mt_start_timeout: got no DoneE expected pulse"); end
        checks++; if ({HI, LO} !== e) begin failures++; $display("FAIL mt_start_hilo: got %h expected %h", {HI, LO}, e); end
    endtask

    task automatic test_ignore_busy();
        logic [63:0] e;
        int busy; bit ok;
        sb.push_back(64'd42);
        launch(MULTU, 32'd6, 32'd7);
        repeat (9) tick();
        StartE = 1'b1; MDOpE = DIVU; MTLOE = 1'b1; Op1E = 32'hDEAD_BEEF; Op2E = 32'd3;
        tick();
        StartE = 1'b0; MTLOE = 1'b0;
        checks++; if (LO !== 32'd12) begin failures++; $display("FAIL busy_mtlo: got %h expected %h", LO, 32'd12); end
        checks++; if (BusyE !== 1'b1) begin failures++; $display("FAIL busy_stray: got %b expected 1", BusyE); end
        wait_done(busy, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin failures++; $display("FAIL busy_timeout: got no DoneE expected pulse"); end
        checks++; if (busy !== 23) begin failures++; $display("FAIL busy_len: got %0d expected 23", busy); end
        checks++; if ({HI, LO} !== e) begin failures++; $display("FAIL busy_hilo: got %h expected %h", {HI, LO}, e); end
    endtask

    task automatic test_abort();
        logic [63:0] e;
        int busy, dones; bit ok;
        launch(MULTU, 32'd5, 32'd5);
        repeat (9) tick();
        AbortE = 1'b1;
        tick();
        AbortE = 1'b0;
        checks++; if (BusyE !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", BusyE); end
        dones = 0;
        repeat (40) begin
            if (DoneE) dones++;
            tick();
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL abort_done: got %0d expected 0", dones); end
        checks++; if ({HI, LO} !== 64'd42) begin failures++; $display("FAIL abort_hold: got %h expected %h", {HI, LO}, 64'd42); end
        sb.push_back(64'd4);
        AbortE = 1'b1;
        launch(MULTU, 32'd2, 32'd2);
        AbortE = 1'b0;
        checks++; if (BusyE !== 1'b1) begin failures++; $display("FAIL abort_idle: got %b expected 1", BusyE); end
        wait_done(busy, ok);
        e = sb.pop_front();
        checks++; if ({HI, LO} !== e) begin failures++; $display("FAIL abort_idle_hilo: got %h expected %h", {HI, LO}, e); end
        launch(MULTU, 32'd9, 32'd9);
        repeat (32) tick();
        AbortE = 1'b1;
        tick();
        AbortE = 1'b0;
        checks++; if ({BusyE, DoneE} !== 2'b00) begin failures++; $display("FAIL abort_fix_flags: got %b expected 00", {BusyE, DoneE}); end
        checks++; if ({HI, LO} !== 64'd4) begin failures++; $display("FAIL abort_fix_hold: got %h expected %h", {HI, LO}, 64'd4); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] e;
        int busy; bit ok;
        launch(DIV, 32'd100, 32'd7);
        repeat (19) tick();
        RST_MDU = 1'b0;
        tick();
        RST_MDU = 1'b1;
        checks++; if ({HI, LO} !== 64'h0) begin failures++; $display("FAIL rstmid_hilo: got %h expected %h", {HI, LO}, 64'h0); end
        checks++; if ({BusyE, DoneE} !== 2'b00) begin failures++; $display("FAIL rstmid_flags: got %b expected 00", {BusyE, DoneE}); end
        sb.push_back(64'd6);
        launch(MULT, 32'd2, 32'd3);
        wait_done(busy, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_timeout: got no DoneE expected pulse"); end
        checks++; if ({HI, LO} !== e) begin failures++; $display("FAIL rstmid_hilo2: got %h expected %h", {HI, LO}, e); end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] e;
        int busy; bit ok;
        for (int i = 0; i < 16; i++) begin
            op = 2'(i % 4);
            a  = (i % 5 == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            sb.push_back(model(op, a, b));
            launch(op, a, b);
            wait_done(busy, ok);
            e = sb.pop_front();
            checks++; if (!ok || {HI, LO} !== e) begin
                failures++; $display("FAIL rand%0d op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, {HI, LO}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_ignore_busy();
        test_abort();
        test_reset_mid();
        test_random();
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL sb_empty: got %0d expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
